// File: rtl/mem_responder_if.sv
// CPU memory port and program-loader port between a CPU/loader master and mem_responder.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] out;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;

    modport master (
        output we, addr, data, load_valid, load_data, load_last,
        input  out, load_ready
    );

    modport slave (
        input  we, addr, data, load_valid, load_data, load_last,
        output out, load_ready
    );
endinterface

// File: rtl/mem_responder.sv
// RAM responder: clears itself, loads a program image, then releases the CPU and serves it.
// Optional macro MEM_RESPONDER_PROTECT_EN drops CPU writes into [PROT_LO, PROT_HI] and flags them.
module mem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PROT_LO    = 8,
    parameter int PROT_HI    = 63
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus,
    output logic            cpu_rst_n,
    output logic            prot_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] r_load_ptr;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_cpu_rst_n;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_load_fire;
    logic                  w_we_one;
    logic                  w_prot_hit;

    // Only an explicit 1 is a write; x/z on we is treated as a read.
    assign w_we_one    = (bus.we === 1'b1);
    assign w_load_fire = (r_state == LOAD) && bus.load_valid;

`ifdef MEM_RESPONDER_PROTECT_EN
    localparam logic [ADDR_WIDTH:0] PROT_LO_A = (ADDR_WIDTH+1)'(PROT_LO);
    localparam logic [ADDR_WIDTH:0] PROT_HI_A = (ADDR_WIDTH+1)'(PROT_HI);
    logic r_prot_err;

    assign w_prot_hit = ({1'b0, bus.addr} >= PROT_LO_A) && ({1'b0, bus.addr} <= PROT_HI_A);
    assign prot_err   = r_prot_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prot_err <= 1'b0;
        end else if ((r_state == RUN) && w_we_one && w_prot_hit) begin
            r_prot_err <= 1'b1;
        end
    end
`else
    assign w_prot_hit = 1'b0;
    assign prot_err   = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_clr_ptr;
        w_mem_wdata  = '0;
        case (r_state)
            CLEAR: begin
                w_mem_we = 1'b1;
                if (r_clr_ptr == ADDR_LAST) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_load_fire) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_load_ptr;
                    w_mem_wdata = bus.load_data;
                    // Image ends on load_last or when the top address is filled.
                    if (bus.load_last || (r_load_ptr == ADDR_LAST)) begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_we_one && !w_prot_hit) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = bus.addr;
                    w_mem_wdata = bus.data;
                end
            end
            default: w_state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_load_ptr  <= '0;
            r_out       <= '0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if (w_load_fire) begin
                r_load_ptr <= r_load_ptr + 1'b1;
            end
            // A write cycle leaves out holding its previous value.
            if ((r_state == RUN) && !w_we_one) begin
                r_out <= r_mem[bus.addr];
            end
            if (r_state == RUN) begin
                r_cpu_rst_n <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign bus.out        = r_out;
    assign bus.load_ready = (r_state == LOAD);
    assign cpu_rst_n      = r_cpu_rst_n;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based memory model.
module tb_mem_responder;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int P_LO  = 8;
    localparam int P_HI  = 63;
`ifdef MEM_RESPONDER_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n;
    logic prot_err;

    mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_LO(P_LO), .PROT_HI(P_HI)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .prot_err  (prot_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] m_out;
    logic          m_prot;
    int            m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check async values, release, and time the self-clear.
    task automatic do_reset();
        int cyc;
        rst_n = 1'b0;
        #2;
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_load_ready", 32'(bus.load_ready), 32'h0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("rst_prot_err", 32'(prot_err), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_out  = '0;
        m_prot = 1'b0;
        m_ptr  = 0;
        cyc = 0;
        while (bus.load_ready !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("clear_cycles", 32'(cyc), 32'd64);
        check("clear_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        $display("txn reset clear_cycles=%0d", cyc);
    endtask

    // Present one loader word after 'gap' idle cycles; returns whether the image is complete.
    task automatic load_word(input logic [DW-1:0] d, input bit last, input int gap, output bit done);
        for (int g = 0; g < gap; g++) step();
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        check("ld_ready", 32'(bus.load_ready), 32'h1);
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
        ref_mem[m_ptr] = d;
        m_ptr++;
        done = last || (m_ptr == DEPTH);
        $display("txn load addr=%0d data=%h last=%0d done=%0d", m_ptr - 1, d, last, done);
    endtask

    // First RUN edge: load_ready drops now, cpu_rst_n rises after the next edge.
    task automatic enter_run();
        check("run_load_ready", 32'(bus.load_ready), 32'h0);
        check("run_cpu_rst_n_pre", 32'(cpu_rst_n), 32'h0);
        check("run_out_held", 32'(bus.out), 32'h0);
    endtask

    task automatic run_cycle(input bit we, input int a, input logic [DW-1:0] d);
        bus.we   = we;
        bus.addr = AW'(a);
        bus.data = d;
        step();
        if (we) begin
            if (PROT_ON && a >= P_LO && a <= P_HI) m_prot = 1'b1;
            else ref_mem[a] = d;
        end else begin
            m_out = ref_mem[a];
        end
        bus.we = 1'b0;
        check(we ? "wr_out_hold" : "rd_out", 32'(bus.out), 32'(m_out));
        check("prot_err", 32'(prot_err), 32'(m_prot));
        check("run_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
        $display("txn run we=%0d addr=%0d data=%h out=%h", we, a, d, bus.out);
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(($urandom_range(0, 2) == 0), $urandom_range(0, DEPTH - 1), DW'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        rst_n          = 1'b0;
        bus.we         = 1'b0;
        bus.addr       = '0;
        bus.data       = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        #1;

        // Reset, then reset again partway through CLEAR: the full clear must restart.
        do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        do_reset();

        // Two-word image with a 2-cycle valid gap.
        load_word(16'h1234, 1'b0, 0, done);
        check("ld2_not_done", 32'(done), 32'h0);
        load_word(16'hABCD, 1'b1, 2, done);
        enter_run();
        run_cycle(1'b0, 1, '0);
        check("rd_abcd", 32'(bus.out), 32'h0000ABCD);
        for (int a = 0; a < DEPTH; a++) run_cycle(1'b0, a, '0);

        // Write then read back, plus protected-region behaviour.
        run_cycle(1'b1, 5, 16'hBEEF);
        run_cycle(1'b0, 5, '0);
        run_cycle(1'b1, 8, 16'hFFFF);
        run_cycle(1'b0, 8, '0);
        run_cycle(1'b1, 3, 16'h5A5A);
        run_cycle(1'b0, 3, '0);
        check("rd_addr3", 32'(bus.out), 32'h00005A5A);
        random_ops(200);

        // Full 64-word image with no load_last: auto transition after the top word.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(DW'(i), 1'b0, $urandom_range(0, 2), done);
            if (done) break;
        end
        check("auto_run_ptr", 32'(m_ptr), 32'd64);
        enter_run();
        run_cycle(1'b0, 63, '0);
        check("rd_63", 32'(bus.out), 32'h0000003F);
        random_ops(100);

        // Reset after 10 of 20 words; the partial image must be gone after reload.
        do_reset();
        for (int i = 0; i < 10; i++) load_word(DW'($urandom), 1'b0, $urandom_range(0, 1), done);
        do_reset();
        load_word(DW'($urandom), 1'b1, 0, done);
        enter_run();
        for (int a = 0; a < 20; a++) run_cycle(1'b0, a, '0);
        random_ops(50);

        // Async drop of cpu_rst_n straight out of RUN.
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
